// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter.
// Holds the selector operation codes driven by the control unit each cycle
// and the width of the selector bus.
package pc_pkg;

   localparam int SEL_W = 3;

   localparam logic [SEL_W-1:0] PC_NEXT     = 3'd0;
   localparam logic [SEL_W-1:0] PC_KEEP     = 3'd1;
   localparam logic [SEL_W-1:0] PC_LOAD     = 3'd2;
   localparam logic [SEL_W-1:0] PC_RELATIVE = 3'd3;
   localparam logic [SEL_W-1:0] PC_CALL     = 3'd4;
   localparam logic [SEL_W-1:0] PC_RETURN   = 3'd5;
   localparam logic [SEL_W-1:0] PC_LOAD_IF  = 3'd6;

endpackage

// File: rtl/return_stack.sv
// Hardware return-address stack (LIFO).
// A push writes entry[count] and a pop reads entry[count-1]; the top entry is
// presented combinationally on pop_data, so a pop on the cycle after a push
// sees the just-written value without any bypass path.
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-low reset
//   push, pop        - requests (never asserted together by the PC)
//   push_data        - value to push
//   pop_data         - current top-of-stack entry
//   count            - number of valid entries
//   full, empty      - count == DEPTH / count == 0
//   push_rejected    - push requested while full (ignored)
//   pop_rejected     - pop requested while empty (ignored)
module return_stack #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       push_rejected,
   output logic                       pop_rejected
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      full          = (count_q == CW'(DEPTH));
      empty         = (count_q == '0);
      do_push       = push & ~full;
      do_pop        = pop & ~empty;
      push_rejected = push & full;
      pop_rejected  = pop & empty;
      wr_idx        = count_q[AW-1:0];
      // Index of the top entry; meaningless (and unused) while empty.
      rd_idx        = AW'(count_q - CW'(1));
      pop_data      = entry_q[rd_idx];
      count_d       = count_q;
      if (do_push) begin
         count_d = count_q + CW'(1);
      end else if (do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Entry storage is not reset; a push coinciding with reset is discarded.
   always_ff @(posedge clock) begin
      if (reset && do_push) begin
         entry_q[wr_idx] <= push_data;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with relative branch, conditional load and
// call/return through a hardware return-address stack.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-low reset
//   selector      - operation code (see pc_pkg)
//   instruction   - absolute target for LOAD, LOAD_IF and CALL
//   offset        - two's-complement displacement for RELATIVE
//   condition     - qualifies LOAD_IF
//   out           - current program counter (registered)
//   stack_count   - valid return-stack entries (registered)
//   stack_full    - stack_count == STACK_DEPTH
//   stack_empty   - stack_count == 0
//   overflow      - sticky, CALL attempted while full
//   underflow     - sticky, RETURN attempted while empty
module program_counter_stack
   import pc_pkg::*;
#(
   parameter int WORD_SIZE     = 15,
   parameter int STACK_DEPTH   = 8,
   parameter int RESET_ADDRESS = 0
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [SEL_W-1:0]                 selector,
   input  logic [WORD_SIZE-1:0]             instruction,
   input  logic [WORD_SIZE-1:0]             offset,
   input  logic                             condition,
   output logic [WORD_SIZE-1:0]             out,
   output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
   output logic                             stack_full,
   output logic                             stack_empty,
   output logic                             overflow,
   output logic                             underflow
);

   logic [WORD_SIZE-1:0] out_q;
   logic [WORD_SIZE-1:0] out_d;
   logic [WORD_SIZE-1:0] out_inc;
   logic                 overflow_q;
   logic                 overflow_d;
   logic                 underflow_q;
   logic                 underflow_d;
   logic                 push;
   logic                 pop;
   logic [WORD_SIZE-1:0] pop_data;
   logic                 push_rejected;
   logic                 pop_rejected;

   return_stack #(
      .WIDTH (WORD_SIZE),
      .DEPTH (STACK_DEPTH)
   ) u_return_stack (
      .clock         (clock),
      .reset         (reset),
      .push          (push),
      .pop           (pop),
      .push_data     (out_inc),
      .pop_data      (pop_data),
      .count         (stack_count),
      .full          (stack_full),
      .empty         (stack_empty),
      .push_rejected (push_rejected),
      .pop_rejected  (pop_rejected)
   );

   always_comb begin
      // Return address is the wrapped sequential successor.
      out_inc = out_q + WORD_SIZE'(1);
      out_d   = out_q;
      push    = 1'b0;
      pop     = 1'b0;
      case (selector)
         PC_NEXT:     out_d = out_inc;
         PC_LOAD:     out_d = instruction;
         // Same-width two's-complement add: an all-ones offset steps back by one.
         PC_RELATIVE: out_d = out_q + offset;
         PC_CALL: begin
            push = 1'b1;
            if (!stack_full) begin
               out_d = instruction;
            end
         end
         PC_RETURN: begin
            pop = 1'b1;
            if (!stack_empty) begin
               out_d = pop_data;
            end
         end
         PC_LOAD_IF:  out_d = condition ? instruction : out_inc;
         default:     out_d = out_q;  // KEEP and the reserved code
      endcase
      overflow_d  = overflow_q | push_rejected;
      underflow_d = underflow_q | pop_rejected;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         out_q       <= WORD_SIZE'(RESET_ADDRESS);
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign out       = out_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_program_counter_stack.sv
module tb_program_counter_stack;
   import pc_pkg::*;

   logic        clock;
   logic        reset;
   logic [2:0]  selector;
   logic [14:0] instruction;
   logic [14:0] offset;
   logic        condition;
   logic [14:0] out;
   logic [3:0]  stack_count;
   logic        stack_full;
   logic        stack_empty;
   logic        overflow;
   logic        underflow;

   program_counter_stack #(
      .WORD_SIZE     (15),
      .STACK_DEPTH   (8),
      .RESET_ADDRESS (0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .selector    (selector),
      .instruction (instruction),
      .offset      (offset),
      .condition   (condition),
      .out         (out),
      .stack_count (stack_count),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [14:0] pc;
      logic [3:0]  cnt;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s %s: got 0x%0h expected 0x%0h", nm, fld, act, req);
      end
   endtask

   // Monitor: outputs settle after the rising edge, compared on the falling edge.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.name, "out", {17'd0, out}, {17'd0, e.pc});
         chk(e.name, "stack_count", {28'd0, stack_count}, {28'd0, e.cnt});
         chk(e.name, "overflow", {31'd0, overflow}, {31'd0, e.ovf});
         chk(e.name, "underflow", {31'd0, underflow}, {31'd0, e.unf});
         chk(e.name, "stack_full", {31'd0, stack_full}, {31'd0, (e.cnt == 4'd8)});
         chk(e.name, "stack_empty", {31'd0, stack_empty}, {31'd0, (e.cnt == 4'd0)});
      end
   end

   // Drive one cycle of stimulus, then queue the state expected after the edge.
   task automatic op(input string nm, input logic rst, input logic [2:0] sel,
                     input logic [14:0] ins, input logic [14:0] off, input logic cond,
                     input logic [14:0] e_pc, input logic [3:0] e_cnt,
                     input logic e_ovf, input logic e_unf);
      exp_t e;
      @(negedge clock);
      reset       = rst;
      selector    = sel;
      instruction = ins;
      offset      = off;
      condition   = cond;
      @(posedge clock);
      #1;
      e.name = nm; e.pc = e_pc; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
      exp_q.push_back(e);
   endtask

   initial begin
      reset = 1'b0; selector = PC_KEEP; instruction = '0; offset = '0; condition = 1'b0;

      // 1. Reset and counting
      op("reset0", 0, PC_KEEP, 15'h0, 15'h0, 0, 15'h0000, 0, 0, 0);
      op("reset1", 0, PC_NEXT, 15'h0, 15'h0, 0, 15'h0000, 0, 0, 0);
      for (int i = 1; i <= 5; i++) op("next", 1, PC_NEXT, 15'h0, 15'h0, 0, 15'(i), 0, 0, 0);
      for (int i = 0; i < 3; i++)  op("keep", 1, PC_KEEP, 15'h0, 15'h0, 0, 15'h0005, 0, 0, 0);

      // 2. Wrap and relative
      op("load_max", 1, PC_LOAD, 15'h7FFF, 15'h0, 0, 15'h7FFF, 0, 0, 0);
      op("wrap", 1, PC_NEXT, 15'h0, 15'h0, 0, 15'h0000, 0, 0, 0);
      op("load_10", 1, PC_LOAD, 15'h0010, 15'h0, 0, 15'h0010, 0, 0, 0);
      op("rel_neg4", 1, PC_RELATIVE, 15'h0, 15'h7FFC, 0, 15'h000C, 0, 0, 0);
      op("rel_pos3", 1, PC_RELATIVE, 15'h0, 15'h0003, 0, 15'h000F, 0, 0, 0);

      // 3. Call/return nesting
      op("load_20", 1, PC_LOAD, 15'h0020, 15'h0, 0, 15'h0020, 0, 0, 0);
      op("call_100", 1, PC_CALL, 15'h0100, 15'h0, 0, 15'h0100, 1, 0, 0);
      op("call_200", 1, PC_CALL, 15'h0200, 15'h0, 0, 15'h0200, 2, 0, 0);
      op("ret_101", 1, PC_RETURN, 15'h0, 15'h0, 0, 15'h0101, 1, 0, 0);
      op("ret_21", 1, PC_RETURN, 15'h0, 15'h0, 0, 15'h0021, 0, 0, 0);

      // 4. Overflow / underflow: pushed values are 0x22, 0x401..0x407
      for (int i = 0; i < 8; i++)
         op("call_fill", 1, PC_CALL, 15'h0400 + 15'(i), 15'h0, 0, 15'h0400 + 15'(i), 4'(i + 1), 0, 0);
      op("call_ovf", 1, PC_CALL, 15'h0300, 15'h0, 0, 15'h0407, 8, 1, 0);
      for (int j = 0; j < 7; j++)
         op("ret_drain", 1, PC_RETURN, 15'h0, 15'h0, 0, 15'h0407 - 15'(j), 4'(7 - j), 1, 0);
      op("ret_last", 1, PC_RETURN, 15'h0, 15'h0, 0, 15'h0022, 0, 1, 0);
      op("ret_unf", 1, PC_RETURN, 15'h0, 15'h0, 0, 15'h0022, 0, 1, 1);
      for (int i = 1; i <= 10; i++)
         op("sticky_next", 1, PC_NEXT, 15'h0, 15'h0, 0, 15'h0022 + 15'(i), 0, 1, 1);

      // 5. Conditional and reserved
      op("load_40", 1, PC_LOAD, 15'h0040, 15'h0, 0, 15'h0040, 0, 1, 1);
      op("ldif_c0", 1, PC_LOAD_IF, 15'h0500, 15'h0, 0, 15'h0041, 0, 1, 1);
      op("ldif_c1", 1, PC_LOAD_IF, 15'h0500, 15'h0, 1, 15'h0500, 0, 1, 1);
      op("reserved", 1, 3'd7, 15'h0123, 15'h0011, 1, 15'h0500, 0, 1, 1);

      // 6. Reset mid-operation
      op("call_600", 1, PC_CALL, 15'h0600, 15'h0, 0, 15'h0600, 1, 1, 1);
      op("call_700", 1, PC_CALL, 15'h0700, 15'h0, 0, 15'h0700, 2, 1, 1);
      op("call_800", 1, PC_CALL, 15'h0800, 15'h0, 0, 15'h0800, 3, 1, 1);
      op("rst_call", 0, PC_CALL, 15'h0900, 15'h0, 0, 15'h0000, 0, 0, 0);
      op("ret_empty", 1, PC_RETURN, 15'h0, 15'h0, 0, 15'h0000, 0, 0, 1);
      op("next_after", 1, PC_NEXT, 15'h0, 15'h0, 0, 15'h0001, 0, 0, 1);
      op("call_50", 1, PC_CALL, 15'h0050, 15'h0, 0, 15'h0050, 1, 0, 1);
      op("ret_pushed", 1, PC_RETURN, 15'h0, 15'h0, 0, 15'h0002, 0, 0, 1);

      // Bounded drain of outstanding expectations
      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
